// File: rtl/trng_pkg.sv
// ---------------------------------------------------------------------------
// trng_pkg
// Shared definitions for the TRNG harvest / MCU transmit path.
//   BYTE_W        width of one harvested byte and of the MCU data bus
//   TX_IDLE..     encodings of the transmit handshake state machine
//   DROP_CNT_MAX  ceiling of the dropped-byte counter
// ---------------------------------------------------------------------------
package trng_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] TX_IDLE    = 2'd0;
    localparam logic [1:0] TX_WAIT_HI = 2'd1;
    localparam logic [1:0] TX_WAIT_LO = 2'd2;

    localparam logic [BYTE_W-1:0] DROP_CNT_MAX = 8'hFF;

endpackage

// File: rtl/trng_fifo.sv
// ---------------------------------------------------------------------------
// trng_fifo
// Synchronous first-word-fall-through byte FIFO.
//   clk_i    clock
//   rst_i    synchronous active-high reset; empties the FIFO
//   push_i   write din_i; accepted when not full, or when full and popping
//   din_i    write data
//   pop_i    remove the head entry (ignored when empty)
//   dout_o   head entry, valid whenever empty_o=0
//   full_o   FIFO holds DEPTH entries
//   empty_o  FIFO holds no entries
// ---------------------------------------------------------------------------
module trng_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when the head leaves in the same
    // cycle: the freed slot is reused, so nothing has to be dropped.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/trng_harvest_tx.sv
// ---------------------------------------------------------------------------
// trng_harvest_tx
// Harvests ring-oscillator jitter into random bytes and hands them to the
// Xmega over a four-phase VALID/ACK byte interface.
//   Raw RO outputs are synchronised, XOR-folded to one parity bit every
//   SAMPLE_DIV clocks, debiased by a von Neumann corrector, packed LSB-first
//   into bytes, buffered in a small FIFO and transmitted.
// Ports
//   CLK        system clock (CLK_50)
//   RST        synchronous active-high reset
//   EN         harvest enable; transmit side keeps draining when low
//   RO_IN      raw ring-oscillator outputs (asynchronous)
//   TX_ACK     MCU acknowledge (asynchronous)
//   TX_DATA    byte presented to the MCU, stable while TX_VALID=1
//   TX_VALID   byte available
//   FIFO_FULL  FIFO holds FIFO_DEPTH bytes
//   DROP_CNT   bytes lost to a full FIFO, saturating at 255
// ---------------------------------------------------------------------------
module trng_harvest_tx
    import trng_pkg::*;
#(
    parameter int N          = 10,
    parameter int SAMPLE_DIV = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [N-1:0]      RO_IN,
    input  logic              TX_ACK,
    output logic [BYTE_W-1:0] TX_DATA,
    output logic              TX_VALID,
    output logic              FIFO_FULL,
    output logic [7:0]        DROP_CNT
);

    localparam int CW  = $clog2(SAMPLE_DIV);
    localparam int BCW = $clog2(BYTE_W);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(BYTE_W - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == DROP_CNT_MAX) ? v : v + 8'd1;
    endfunction

    // Synchronisers
    logic [N-1:0] ro_meta_q, ro_sync_q;
    logic         ack_meta_q, ack_sync_q;

    // Sampling, corrector and packer state
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic              phase_q, phase_d;   // 1: first sample of a pair held
    logic              first_q, first_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]    bcnt_q,  bcnt_d;

    // Transmit and overflow state
    logic [1:0]        state_q, state_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        drop_q, drop_d;

    logic              tick, parity, emit;
    logic [BYTE_W-1:0] byte_next;
    logic              push, pop;
    logic [BYTE_W-1:0] fifo_dout;
    logic              fifo_full, fifo_empty;

    assign tick      = EN && (cnt_q == CNT_LAST);
    assign parity    = ^ro_sync_q;
    // New bits enter at the MSB so that after eight shifts the first bit
    // emitted has landed in bit 0.
    assign byte_next = {first_q, shreg_q[BYTE_W-1:1]};

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        first_d = first_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        emit    = 1'b0;
        push    = 1'b0;

        if (!EN) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Unequal pairs emit their first sample: 10 -> 1, 01 -> 0.
        if (tick) begin
            if (!phase_q) begin
                first_d = parity;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                emit    = (first_q != parity);
            end
        end

        if (emit) begin
            shreg_d = byte_next;
            if (bcnt_q == BIT_LAST) begin
                push   = 1'b1;
                bcnt_d = '0;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        pop        = 1'b0;
        drop_d     = drop_q;

        case (state_q)
            TX_IDLE: begin
                // A high ACK here is stale from a faulty MCU; wait for it
                // to fall before offering anything new.
                if (!fifo_empty && !ack_sync_q) begin
                    pop        = 1'b1;
                    tx_data_d  = fifo_dout;
                    tx_valid_d = 1'b1;
                    state_d    = TX_WAIT_HI;
                end
            end
            TX_WAIT_HI: begin
                if (ack_sync_q) begin
                    tx_valid_d = 1'b0;
                    state_d    = TX_WAIT_LO;
                end
            end
            TX_WAIT_LO: begin
                if (!ack_sync_q) begin
                    state_d = TX_IDLE;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = TX_IDLE;
            end
        endcase

        if (push && fifo_full && !pop) begin
            drop_d = sat_inc(drop_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ro_meta_q  <= '0;
            ro_sync_q  <= '0;
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            first_q    <= 1'b0;
            shreg_q    <= '0;
            bcnt_q     <= '0;
            state_q    <= TX_IDLE;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            ro_meta_q  <= RO_IN;
            ro_sync_q  <= ro_meta_q;
            ack_meta_q <= TX_ACK;
            ack_sync_q <= ack_meta_q;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            first_q    <= first_d;
            shreg_q    <= shreg_d;
            bcnt_q     <= bcnt_d;
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            drop_q     <= drop_d;
        end
    end

    trng_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (push),
        .din_i   (byte_next),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign TX_DATA   = tx_data_q;
    assign TX_VALID  = tx_valid_q;
    assign FIFO_FULL = fifo_full;
    assign DROP_CNT  = drop_q;

endmodule

// File: tb/tb_trng_harvest_tx.sv
// ---------------------------------------------------------------------------
// tb_trng_harvest_tx
// Directed bench for trng_harvest_tx with SAMPLE_DIV=2, FIFO_DEPTH=4.
// A stream-level model (sample pairs -> bits -> bytes -> bounded queue with
// drop counter) is checked against the DUT on every falling edge; directed
// literal checks pin reset values, byte values and handshake timing.
// ---------------------------------------------------------------------------
module tb_trng_harvest_tx;

    localparam int N     = 10;
    localparam int DIV   = 2;
    localparam int DEPTH = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         EN = 1'b0;
    logic [N-1:0] RO_IN = '0;
    logic         TX_ACK = 1'b0;
    logic [7:0]   TX_DATA;
    logic         TX_VALID;
    logic         FIFO_FULL;
    logic [7:0]   DROP_CNT;

    trng_harvest_tx #(.N(N), .SAMPLE_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .RO_IN     (RO_IN),
        .TX_ACK    (TX_ACK),
        .TX_DATA   (TX_DATA),
        .TX_VALID  (TX_VALID),
        .FIFO_FULL (FIFO_FULL),
        .DROP_CNT  (DROP_CNT)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- stream model ----------------
    int         m_phase = 0;
    bit         m_first = 1'b0;
    int         m_nbits = 0;
    logic [7:0] m_acc = '0;
    logic [7:0] exp_q[$];
    int         exp_drop = 0;

    task automatic model_clear();
        m_phase = 0; m_first = 1'b0; m_nbits = 0; m_acc = '0;
        exp_q.delete();
        exp_drop = 0;
    endtask

    task automatic model_bit(input bit b);
        m_acc[m_nbits] = b;
        m_nbits++;
        if (m_nbits == 8) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(m_acc);
            else if (exp_drop < 255) exp_drop++;
            m_nbits = 0;
            m_acc   = '0;
        end
    endtask

    task automatic model_sample(input bit p);
        if (m_phase == 0) begin
            m_first = p;
            m_phase = 1;
        end else begin
            m_phase = 0;
            if (m_first != p) model_bit(m_first);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    bit smp[$];

    function automatic logic [N-1:0] enc(input bit p);
        logic [N-1:0] v;
        v = N'($urandom);
        if ((^v) != p) v[0] = ~v[0];
        return v;
    endfunction

    // Drives the queued parity samples so that each is seen at exactly one
    // terminal count; the counter sits at 0 with EN low before and after.
    task automatic burst();
        int n;
        n = smp.size();
        if (n == 0) return;
        @(posedge CLK); #1 RO_IN = enc(smp[0]);
        @(posedge CLK); #1 EN = 1'b1;
        for (int m = 0; m < n; m++) begin
            @(posedge CLK); #1;
            if (m + 1 < n) RO_IN = enc(smp[m+1]);
            @(posedge CLK); #1;
            model_sample(smp[m]);
        end
        EN = 1'b0;
        smp.delete();
    endtask

    task automatic add_bit(input bit b);
        if (b) begin smp.push_back(1'b1); smp.push_back(1'b0); end
        else   begin smp.push_back(1'b0); smp.push_back(1'b1); end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 8; k++) add_bit(b[k]);
        burst();
    endtask

    task automatic do_reset(input bit check);
        @(posedge CLK); #1 RST = 1'b1; EN = 1'b0; TX_ACK = 1'b0;
        @(posedge CLK); #1;
        if (check) begin
            chk("rst_tx_valid", TX_VALID, 0);
            chk("rst_tx_data", TX_DATA, 0);
            chk("rst_fifo_full", FIFO_FULL, 0);
            chk("rst_drop_cnt", DROP_CNT, 0);
        end
        model_clear();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!TX_VALID && n < budget) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!TX_VALID) chk({name, "_timeout"}, 0, 1);
    endtask

    // One MCU handshake on the byte currently offered. When next_pending is
    // set a further byte is queued and its presentation edge is checked:
    // ACK low reaches the FSM after two sync edges, it returns to IDLE on the
    // third and pops on the fourth.
    task automatic handshake(input logic [7:0] exp_data, input bit next_pending);
        int n;
        wait_valid("hs_valid", 200);
        chk("hs_data", TX_DATA, exp_data);
        repeat (5) @(posedge CLK);
        #1 TX_ACK = 1'b1;
        n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (TX_VALID && n < 10);
        chk("hs_ack_to_valid_low", n, 3);
        repeat (2) @(posedge CLK);
        #1 TX_ACK = 1'b0;
        if (next_pending) begin
            n = 0;
            do begin
                @(posedge CLK); #1;
                n++;
            end while (!TX_VALID && n < 10);
            chk("hs_ack_low_to_next_valid", n, 4);
        end
    endtask

    // ---------------- compare process ----------------
    bit         prev_valid = 1'b0;
    logic [7:0] held = '0;

    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (TX_VALID && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("model_unexpected_byte", TX_DATA, -1);
                    end else begin
                        chk("model_tx_data", TX_DATA, exp_q.pop_front());
                    end
                    held = TX_DATA;
                end else if (TX_VALID) begin
                    chk("model_tx_data_stable", TX_DATA, held);
                end
                chk("model_fifo_full", FIFO_FULL, (exp_q.size() == DEPTH) ? 1 : 0);
                chk("model_drop_cnt", DROP_CNT, exp_drop);
            end
            prev_valid = TX_VALID;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        do_reset(1'b1);

        // Parity 1,0 x8 -> eight 1 bits -> 0xFF, VALID one edge after write
        for (int i = 0; i < 8; i++) begin smp.push_back(1'b1); smp.push_back(1'b0); end
        burst();
        chk("t1_valid_at_write_edge", TX_VALID, 0);
        @(posedge CLK); #1;
        chk("t1_valid_next_edge", TX_VALID, 1);
        chk("t1_data", TX_DATA, 8'hFF);

        // Pairs 01,10 x4 -> 0xAA, queued behind 0xFF; full handshake timing
        for (int i = 0; i < 4; i++) begin
            smp.push_back(1'b0); smp.push_back(1'b1);
            smp.push_back(1'b1); smp.push_back(1'b0);
        end
        burst();
        handshake(8'hFF, 1'b1);
        handshake(8'hAA, 1'b0);

        // Equal pairs 00/11 interleaved emit nothing: still 0xAA
        smp = '{0,1, 0,0, 1,0, 1,1, 0,1, 1,0, 0,0, 0,1, 1,0, 1,1, 0,1, 1,0};
        burst();
        @(posedge CLK); #1;
        chk("t2_valid", TX_VALID, 1);
        chk("t2_data_equal_pairs", TX_DATA, 8'hAA);
        handshake(8'hAA, 1'b0);

        // EN low after 3 bits (mid-pair), then 5 more bits -> one byte 0x3C
        smp = '{0,1, 0,1, 1,0, 1};
        burst();
        repeat (20) @(posedge CLK);
        #1 chk("t5_no_byte_while_disabled", TX_VALID, 0);
        smp = '{0, 1,0, 1,0, 0,1, 0,1};
        burst();
        @(posedge CLK); #1;
        chk("t5_valid", TX_VALID, 1);
        chk("t5_data", TX_DATA, 8'h3C);
        handshake(8'h3C, 1'b0);
        repeat (4) @(posedge CLK);

        // ACK stuck low: 7 bytes -> 1 held, 4 queued, 2 dropped
        for (int i = 1; i <= 7; i++) send_byte(8'(i * 8'h11));
        repeat (2) @(posedge CLK);
        #1;
        chk("t4_valid_held", TX_VALID, 1);
        chk("t4_data_held", TX_DATA, 8'h11);
        chk("t4_fifo_full", FIFO_FULL, 1);
        chk("t4_drop_cnt_2", DROP_CNT, 2);
        for (int i = 0; i < 300; i++) send_byte(8'(i));
        repeat (2) @(posedge CLK);
        #1;
        chk("t4_drop_cnt_sat", DROP_CNT, 255);
        chk("t4_fifo_full_after", FIFO_FULL, 1);

        // Reset from full/saturated state clears everything
        do_reset(1'b1);

        // Reset during WAIT_HI with 2 bytes queued and a partial byte pending
        send_byte(8'h81);
        send_byte(8'h7E);
        send_byte(8'hC3);
        smp = '{1,0, 0,1, 1};
        burst();
        #0 chk("t6_valid_before_reset", TX_VALID, 1);
        do_reset(1'b1);
        // 7 fresh bits: no byte may appear yet
        for (int k = 0; k < 7; k++) add_bit(k[0] ? 1'b1 : (k == 4));
        burst();
        repeat (3) @(posedge CLK);
        #1 chk("t6_no_byte_after_7_bits", TX_VALID, 0);
        add_bit(1'b0);
        burst();
        @(posedge CLK); #1;
        chk("t6_valid_fresh", TX_VALID, 1);
        // bits 0..7 = 0,1,0,1,1,1,0,0 -> 0x3A
        chk("t6_data_fresh", TX_DATA, 8'h3A);
        handshake(8'h3A, 1'b0);
        repeat (6) @(posedge CLK);
        #1 chk("end_model_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
